// File: rtl/jtag_dm_pkg.sv
// Shared definitions for the debug module: DMI register map, op codes,
// abstract-command error codes, FSM states and COMMAND field positions.
package jtag_dm_pkg;

    localparam logic [6:0] ADDR_DATA0      = 7'h04;
    localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
    localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
    localparam logic [6:0] ADDR_COMMAND    = 7'h17;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        CMDERR_NONE       = 2'd0,
        CMDERR_NOT_HALTED = 2'd1,
        CMDERR_PENDING    = 2'd2
    } cmderr_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SAMPLE,
        ST_RESP
    } state_e;

    localparam int unsigned CMD_REGNO_MSB    = 4;
    localparam int unsigned CMD_WRITE_BIT    = 16;
    localparam int unsigned CMD_TRANSFER_BIT = 17;

endpackage

// File: rtl/jtag_dm_cnt.sv
// Load / decrement-or-saturating-increment counter used for the reset pulse
// length and the halt settle time.
module dm_cnt #(
    parameter int unsigned      WIDTH    = 8,
    parameter bit               COUNT_UP = 1'b0,
    parameter logic [WIDTH-1:0] LIMIT    = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            if (COUNT_UP) begin
                if (r_count != LIMIT) r_count <= r_count + WIDTH'(1);
            end else begin
                if (r_count != '0) r_count <= r_count - WIDTH'(1);
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/jtag_dm.sv
// Debug module: DMI register front end plus a small abstract-command engine
// that turns GPR access commands into cycles on the core's debug register port.
module jtag_dm
    import jtag_dm_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned HALT_SETTLE  = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        dmi_req_valid,
    output logic        dmi_req_ready,
    input  logic [1:0]  dmi_req_op,
    input  logic [6:0]  dmi_req_addr,
    input  logic [31:0] dmi_req_data,
    output logic        dmi_resp_valid,
    input  logic        dmi_resp_ready,
    output logic [31:0] dmi_resp_data,
    output logic        dmi_resp_err,
    output logic        jtag_halt,
    output logic        jtag_reset,
    output logic        reg_wen,
    output logic [4:0]  reg_addr,
    output logic [31:0] reg_w_data,
    input  logic [31:0] reg_r_data
);

    localparam int unsigned RST_W  = $clog2(RESET_CYCLES + 1);
    localparam int unsigned HALT_W = $clog2(HALT_SETTLE + 1);

    state_e      r_state, w_next_state;
    logic [31:0] r_data0;
    logic        r_haltreq;
    cmderr_e     r_cmderr;
    logic [4:0]  r_regno;
    logic        r_cmd_write;
    logic [31:0] r_resp_data;
    logic        r_resp_err;

    logic              w_accept, w_is_read, w_is_write;
    logic              w_wr_dmctrl, w_cmd_xfer, w_cmd_start, w_cmd_reject;
    logic              w_busy, w_halted, w_resetting, w_unmapped;
    logic [31:0]       w_rd_data;
    logic [RST_W-1:0]  w_rst_cnt;
    logic [HALT_W-1:0] w_halt_cnt;
    dmi_op_e           w_op;

    assign w_op       = dmi_op_e'(dmi_req_op);
    assign w_accept   = dmi_req_valid & dmi_req_ready;
    assign w_is_read  = w_accept & (w_op == OP_READ);
    assign w_is_write = w_accept & (w_op == OP_WRITE);

    assign w_wr_dmctrl  = w_is_write & (dmi_req_addr == ADDR_DMCONTROL);
    assign w_cmd_xfer   = w_is_write & (dmi_req_addr == ADDR_COMMAND)
                        & dmi_req_data[CMD_TRANSFER_BIT] & (r_cmderr == CMDERR_NONE);
    assign w_cmd_start  = w_cmd_xfer & w_halted;
    assign w_cmd_reject = w_cmd_xfer & ~w_halted;

    assign w_halted    = (w_halt_cnt == HALT_W'(HALT_SETTLE));
    assign w_resetting = (w_rst_cnt != '0);

    dm_cnt #(
        .WIDTH    (RST_W),
        .COUNT_UP (1'b0),
        .LIMIT    ('0)
    ) u_rst_cnt (
        .clk        (clk),
        .rstn       (rstn),
        .i_clr      (1'b0),
        .i_load     (w_wr_dmctrl & dmi_req_data[1]),
        .i_load_val (RST_W'(RESET_CYCLES)),
        .i_en       (1'b1),
        .o_count    (w_rst_cnt)
    );

    // Clearing haltreq must drop halted on the same edge, hence the clear port.
    dm_cnt #(
        .WIDTH    (HALT_W),
        .COUNT_UP (1'b1),
        .LIMIT    (HALT_W'(HALT_SETTLE))
    ) u_halt_cnt (
        .clk        (clk),
        .rstn       (rstn),
        .i_clr      (w_wr_dmctrl & ~dmi_req_data[0]),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (r_haltreq),
        .o_count    (w_halt_cnt)
    );

    always_comb begin
        w_rd_data  = '0;
        w_unmapped = 1'b0;
        case (dmi_req_addr)
            ADDR_DATA0:      w_rd_data = r_data0;
            ADDR_DMCONTROL:  w_rd_data = {31'b0, r_haltreq};
            ADDR_DMSTATUS:   w_rd_data = {30'b0, w_resetting, w_halted};
            ADDR_ABSTRACTCS: w_rd_data = {29'b0, r_cmderr, w_busy};
            ADDR_COMMAND:    w_rd_data = '0;
            default:         w_unmapped = 1'b1;
        endcase
    end

    always_comb begin
        w_next_state   = r_state;
        dmi_req_ready  = 1'b0;
        dmi_resp_valid = 1'b0;
        reg_wen        = 1'b0;
        reg_addr       = '0;
        reg_w_data     = '0;
        w_busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                dmi_req_ready = rstn;
                if (w_accept) w_next_state = w_cmd_start ? ST_EXEC : ST_RESP;
            end
            ST_EXEC: begin
                w_busy   = 1'b1;
                reg_addr = r_regno;
                if (r_cmd_write) begin
                    reg_wen      = 1'b1;
                    reg_w_data   = r_data0;
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                w_busy       = 1'b1;
                reg_addr     = r_regno;
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                dmi_resp_valid = 1'b1;
                if (dmi_resp_ready) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_data0     <= '0;
            r_haltreq   <= 1'b0;
            r_cmderr    <= CMDERR_NONE;
            r_regno     <= '0;
            r_cmd_write <= 1'b0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_resp_data <= w_is_read ? w_rd_data : '0;
                r_resp_err  <= (w_is_read | w_is_write) & w_unmapped;
            end
            if (w_is_write) begin
                case (dmi_req_addr)
                    ADDR_DATA0:      r_data0   <= dmi_req_data;
                    ADDR_DMCONTROL:  r_haltreq <= dmi_req_data[0];
                    ADDR_ABSTRACTCS: r_cmderr  <= cmderr_e'(r_cmderr & ~dmi_req_data[2:1]);
                    default: ;
                endcase
            end
            if (w_cmd_start) begin
                r_regno     <= dmi_req_data[CMD_REGNO_MSB:0];
                r_cmd_write <= dmi_req_data[CMD_WRITE_BIT];
            end
            if (w_cmd_reject) r_cmderr <= CMDERR_NOT_HALTED;
            // A read command's response returns the freshly sampled DATA0.
            if (r_state == ST_SAMPLE) begin
                r_data0     <= reg_r_data;
                r_resp_data <= reg_r_data;
            end
        end
    end

    assign dmi_resp_data = r_resp_data;
    assign dmi_resp_err  = r_resp_err;
    assign jtag_halt     = r_haltreq;
    assign jtag_reset    = w_resetting;

endmodule

// File: tb/tb_jtag_dm.sv
// Directed bench for jtag_dm: register-access vector table plus hand-written
// sequences for halt settle, command timing, reset pulse, back-pressure and rstn.
module tb_jtag_dm;

    logic        clk = 1'b0;
    logic        rstn;
    logic        dmi_req_valid;
    logic        dmi_req_ready;
    logic [1:0]  dmi_req_op;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic        dmi_resp_valid;
    logic        dmi_resp_ready;
    logic [31:0] dmi_resp_data;
    logic        dmi_resp_err;
    logic        jtag_halt;
    logic        jtag_reset;
    logic        reg_wen;
    logic [4:0]  reg_addr;
    logic [31:0] reg_w_data;
    logic [31:0] reg_r_data;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rst_hi_total = 0;
    int rise_cyc = -1;
    logic rst_prev = 1'b0;
    int wen_total = 0;
    logic [4:0]  wen_addr = '0;
    logic [31:0] wen_data = '0;

    jtag_dm #(
        .RESET_CYCLES (16),
        .HALT_SETTLE  (4)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .dmi_req_valid  (dmi_req_valid),
        .dmi_req_ready  (dmi_req_ready),
        .dmi_req_op     (dmi_req_op),
        .dmi_req_addr   (dmi_req_addr),
        .dmi_req_data   (dmi_req_data),
        .dmi_resp_valid (dmi_resp_valid),
        .dmi_resp_ready (dmi_resp_ready),
        .dmi_resp_data  (dmi_resp_data),
        .dmi_resp_err   (dmi_resp_err),
        .jtag_halt      (jtag_halt),
        .jtag_reset     (jtag_reset),
        .reg_wen        (reg_wen),
        .reg_addr       (reg_addr),
        .reg_w_data     (reg_w_data),
        .reg_r_data     (reg_r_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // GPR file model: registered read, GPR3 holds a known pattern.
    always @(posedge clk)
        reg_r_data <= (reg_addr == 5'd3) ? 32'h1234_5678 : (32'hBAD0_0000 | {27'b0, reg_addr});

    always @(negedge clk) begin
        if (jtag_reset) rst_hi_total++;
        if (jtag_reset && !rst_prev) rise_cyc = cyc;
        rst_prev = jtag_reset;
        if (reg_wen) begin
            wen_total++;
            wen_addr = reg_addr;
            wen_data = reg_w_data;
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                        output logic [31:0] rdata, output logic rerr, output int lat);
        int guard;
        @(negedge clk);
        dmi_req_valid  = 1'b1;
        dmi_req_op     = op;
        dmi_req_addr   = addr;
        dmi_req_data   = data;
        dmi_resp_ready = 1'b1;
        guard = 0;
        while (!dmi_req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready wait", {31'b0, dmi_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        dmi_req_valid = 1'b0;
        rdata = '0;
        rerr  = 1'b0;
        lat   = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (dmi_resp_valid) begin
                rdata = dmi_resp_data;
                rerr  = dmi_resp_err;
                break;
            end
        end
        chk("resp_valid wait", {31'b0, dmi_resp_valid}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic rw(input string name, input logic [1:0] op, input logic [6:0] addr,
                      input logic [31:0] data, input logic [31:0] exp_data, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lt;
        xfer(op, addr, data, rd, er, lt);
        chk({name, " data"}, rd, exp_data);
        chk({name, " lat"}, 32'(lt), 32'(exp_lat));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt;
        int          snap;

        vecs[0]  = '{2'd1, 7'h10, 32'h0,         32'h0,         1'b0, 1};
        vecs[1]  = '{2'd1, 7'h11, 32'h0,         32'h0,         1'b0, 1};
        vecs[2]  = '{2'd1, 7'h04, 32'h0,         32'h0,         1'b0, 1};
        vecs[3]  = '{2'd1, 7'h16, 32'h0,         32'h0,         1'b0, 1};
        vecs[4]  = '{2'd2, 7'h04, 32'hA5A5_0F0F, 32'h0,         1'b0, 1};
        vecs[5]  = '{2'd1, 7'h04, 32'h0,         32'hA5A5_0F0F, 1'b0, 1};
        vecs[6]  = '{2'd1, 7'h7F, 32'h0,         32'h0,         1'b1, 1};
        vecs[7]  = '{2'd2, 7'h7F, 32'h1,         32'h0,         1'b1, 1};
        vecs[8]  = '{2'd1, 7'h04, 32'h0,         32'hA5A5_0F0F, 1'b0, 1};
        vecs[9]  = '{2'd0, 7'h04, 32'hFFFF_FFFF, 32'h0,         1'b0, 1};
        vecs[10] = '{2'd3, 7'h04, 32'h0,         32'h0,         1'b0, 1};
        vecs[11] = '{2'd1, 7'h04, 32'h0,         32'hA5A5_0F0F, 1'b0, 1};
        vecs[12] = '{2'd2, 7'h17, 32'h0002_0001, 32'h0,         1'b0, 1};
        vecs[13] = '{2'd1, 7'h16, 32'h0,         32'h2,         1'b0, 1};
        vecs[14] = '{2'd2, 7'h17, 32'h0003_0002, 32'h0,         1'b0, 1};
        vecs[15] = '{2'd1, 7'h16, 32'h0,         32'h2,         1'b0, 1};
        vecs[16] = '{2'd2, 7'h16, 32'h6,         32'h0,         1'b0, 1};
        vecs[17] = '{2'd1, 7'h16, 32'h0,         32'h0,         1'b0, 1};
        vecs[18] = '{2'd2, 7'h17, 32'h0000_0005, 32'h0,         1'b0, 1};
        vecs[19] = '{2'd1, 7'h16, 32'h0,         32'h0,         1'b0, 1};
        vecs[20] = '{2'd1, 7'h17, 32'h0,         32'h0,         1'b0, 1};
        vecs[21] = '{2'd2, 7'h11, 32'h3,         32'h0,         1'b0, 1};
        vecs[22] = '{2'd1, 7'h11, 32'h0,         32'h0,         1'b0, 1};

        rstn           = 1'b0;
        dmi_req_valid  = 1'b0;
        dmi_req_op     = 2'd0;
        dmi_req_addr   = '0;
        dmi_req_data   = '0;
        dmi_resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs",
            {dmi_req_ready, dmi_resp_valid, dmi_resp_err, jtag_halt, jtag_reset, reg_wen, 26'b0},
            32'h0);
        chk("reset reg_addr", {27'b0, reg_addr}, 32'h0);
        chk("reset reg_w_data", reg_w_data, 32'h0);
        chk("reset resp_data", dmi_resp_data, 32'h0);
        rstn = 1'b1;
        @(negedge clk);
        chk("ready after reset", {31'b0, dmi_req_ready}, 32'd1);

        snap = wen_total;
        for (int i = 0; i < 23; i++) begin
            xfer(vecs[i].op, vecs[i].addr, vecs[i].data, rd, er, lt);
            chk($sformatf("vec%0d data", i), rd, vecs[i].exp_data);
            chk($sformatf("vec%0d err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            chk($sformatf("vec%0d lat", i), 32'(lt), 32'(vecs[i].exp_lat));
        end
        chk("no reg_wen while not halted", 32'(wen_total - snap), 32'd0);

        // ndmreset pulse: 16 cycles, rising right after the accept edge
        snap = rst_hi_total;
        rw("ndmreset", 2'd2, 7'h10, 32'h2, 32'h0, 1);
        chk("jtag_reset rise cycle", 32'(rise_cyc), 32'(acc_cyc));
        rw("dmstatus resetting", 2'd1, 7'h11, 32'h0, 32'h2, 1);
        repeat (30) @(posedge clk);
        chk("jtag_reset length", 32'(rst_hi_total - snap), 32'd16);

        // rewrite 8 cycles into the pulse extends it to 24 cycles
        snap = rst_hi_total;
        rw("ndmreset first", 2'd2, 7'h10, 32'h2, 32'h0, 1);
        repeat (6) @(posedge clk);
        rw("ndmreset rewrite", 2'd2, 7'h10, 32'h2, 32'h0, 1);
        repeat (40) @(posedge clk);
        chk("jtag_reset extended length", 32'(rst_hi_total - snap), 32'd24);

        // halt settle: DMSTATUS read at +2, +4, +6 cycles after haltreq
        rw("haltreq", 2'd2, 7'h10, 32'h1, 32'h0, 1);
        chk("jtag_halt", {31'b0, jtag_halt}, 32'd1);
        rw("dmstatus +2", 2'd1, 7'h11, 32'h0, 32'h0, 1);
        rw("dmstatus +4", 2'd1, 7'h11, 32'h0, 32'h0, 1);
        rw("dmstatus +6", 2'd1, 7'h11, 32'h0, 32'h1, 1);
        rw("dmcontrol rd", 2'd1, 7'h10, 32'h0, 32'h1, 1);

        // write command: one reg_wen cycle to GPR5 with DATA0
        rw("data0 wr", 2'd2, 7'h04, 32'hDEAD_BEEF, 32'h0, 1);
        snap = wen_total;
        rw("wr cmd", 2'd2, 7'h17, 32'h0003_0005, 32'h0, 2);
        chk("wr cmd wen count", 32'(wen_total - snap), 32'd1);
        chk("wr cmd reg_addr", {27'b0, wen_addr}, 32'd5);
        chk("wr cmd reg_w_data", wen_data, 32'hDEAD_BEEF);

        // read command: GPR3 into DATA0
        snap = wen_total;
        rw("rd cmd", 2'd2, 7'h17, 32'h0002_0003, 32'h1234_5678, 3);
        chk("rd cmd wen count", 32'(wen_total - snap), 32'd0);
        rw("data0 after rd cmd", 2'd1, 7'h04, 32'h0, 32'h1234_5678, 1);
        rw("abstractcs after cmds", 2'd1, 7'h16, 32'h0, 32'h0, 1);

        // response back-pressure
        @(negedge clk);
        dmi_req_valid  = 1'b1;
        dmi_req_op     = 2'd1;
        dmi_req_addr   = 7'h04;
        dmi_req_data   = '0;
        dmi_resp_ready = 1'b0;
        chk("bp ready before", {31'b0, dmi_req_ready}, 32'd1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d resp_valid", k), {31'b0, dmi_resp_valid}, 32'd1);
            chk($sformatf("bp%0d resp_data", k), dmi_resp_data, 32'h1234_5678);
            chk($sformatf("bp%0d resp_err", k), {31'b0, dmi_resp_err}, 32'd0);
            chk($sformatf("bp%0d req_ready", k), {31'b0, dmi_req_ready}, 32'd0);
        end
        dmi_req_valid  = 1'b0;
        dmi_resp_ready = 1'b1;
        @(negedge clk);
        chk("bp released resp_valid", {31'b0, dmi_resp_valid}, 32'd0);
        chk("bp released req_ready", {31'b0, dmi_req_ready}, 32'd1);

        // rstn asserted while the read command is in SAMPLE
        dmi_req_valid = 1'b1;
        dmi_req_op    = 2'd2;
        dmi_req_addr  = 7'h17;
        dmi_req_data  = 32'h0002_0007;
        @(posedge clk);
        #1;
        dmi_req_valid = 1'b0;
        @(negedge clk);
        chk("exec reg_addr", {27'b0, reg_addr}, 32'd7);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("rst in sample outputs",
            {dmi_req_ready, dmi_resp_valid, dmi_resp_err, jtag_halt, jtag_reset, reg_wen, 26'b0},
            32'h0);
        chk("rst in sample reg_addr", {27'b0, reg_addr}, 32'h0);
        chk("rst in sample resp_data", dmi_resp_data, 32'h0);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle after rst", {31'b0, dmi_req_ready}, 32'd1);
        rw("data0 after rst", 2'd1, 7'h04, 32'h0, 32'h0, 1);
        rw("dmcontrol after rst", 2'd1, 7'h10, 32'h0, 32'h0, 1);
        rw("dmstatus after rst", 2'd1, 7'h11, 32'h0, 32'h0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
